// File: rtl/hsi2rgb_pipe.sv
// HSI to 8-bit RGB converter: 4-stage valid-tagged pipeline with a global
// advance enable. Hue is reduced to a 0..119 offset inside one of three sectors.
module hsi2rgb_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       iEn,
  input  logic       iValid,
  input  logic [8:0] iH,
  input  logic [7:0] iS,
  input  logic [7:0] iI,
  output logic       oValid,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB
);

  // Flow control: iEn is the only handshake. iEn = 1 shifts every stage by one,
  // iEn = 0 freezes every register (including outputs). iValid only tags data.

  // K(h') = round(256*cos(h')/cos(60-h')), 11-bit signed
  function automatic logic signed [10:0] k_lut(input logic [6:0] hp);
    logic signed [10:0] k;
    k = 11'sd0;
    case (hp)
      7'd0:   k = 11'sd512;  7'd1:   k = 11'sd497;  7'd2:   k = 11'sd483;  7'd3:   k = 11'sd469;  7'd4:   k = 11'sd457;
      7'd5:   k = 11'sd445;  7'd6:   k = 11'sd433;  7'd7:   k = 11'sd422;  7'd8:   k = 11'sd412;  7'd9:   k = 11'sd402;
      7'd10:  k = 11'sd392;  7'd11:  k = 11'sd383;  7'd12:  k = 11'sd374;  7'd13:  k = 11'sd366;  7'd14:  k = 11'sd358;
      7'd15:  k = 11'sd350;  7'd16:  k = 11'sd342;  7'd17:  k = 11'sd335;  7'd18:  k = 11'sd328;  7'd19:  k = 11'sd321;
      7'd20:  k = 11'sd314;  7'd21:  k = 11'sd308;  7'd22:  k = 11'sd301;  7'd23:  k = 11'sd295;  7'd24:  k = 11'sd289;
      7'd25:  k = 11'sd283;  7'd26:  k = 11'sd278;  7'd27:  k = 11'sd272;  7'd28:  k = 11'sd267;  7'd29:  k = 11'sd261;
      7'd30:  k = 11'sd256;  7'd31:  k = 11'sd251;  7'd32:  k = 11'sd246;  7'd33:  k = 11'sd241;  7'd34:  k = 11'sd236;
      7'd35:  k = 11'sd231;  7'd36:  k = 11'sd227;  7'd37:  k = 11'sd222;  7'd38:  k = 11'sd218;  7'd39:  k = 11'sd213;
      7'd40:  k = 11'sd209;  7'd41:  k = 11'sd204;  7'd42:  k = 11'sd200;  7'd43:  k = 11'sd196;  7'd44:  k = 11'sd192;
      7'd45:  k = 11'sd187;  7'd46:  k = 11'sd183;  7'd47:  k = 11'sd179;  7'd48:  k = 11'sd175;  7'd49:  k = 11'sd171;
      7'd50:  k = 11'sd167;  7'd51:  k = 11'sd163;  7'd52:  k = 11'sd159;  7'd53:  k = 11'sd155;  7'd54:  k = 11'sd151;
      7'd55:  k = 11'sd147;  7'd56:  k = 11'sd144;  7'd57:  k = 11'sd140;  7'd58:  k = 11'sd136;  7'd59:  k = 11'sd132;
      7'd60:  k = 11'sd128;  7'd61:  k = 11'sd124;  7'd62:  k = 11'sd120;  7'd63:  k = 11'sd116;  7'd64:  k = 11'sd112;
      7'd65:  k = 11'sd109;  7'd66:  k = 11'sd105;  7'd67:  k = 11'sd101;  7'd68:  k = 11'sd97;   7'd69:  k = 11'sd93;
      7'd70:  k = 11'sd89;   7'd71:  k = 11'sd85;   7'd72:  k = 11'sd81;   7'd73:  k = 11'sd77;   7'd74:  k = 11'sd73;
      7'd75:  k = 11'sd69;   7'd76:  k = 11'sd64;   7'd77:  k = 11'sd60;   7'd78:  k = 11'sd56;   7'd79:  k = 11'sd52;
      7'd80:  k = 11'sd47;   7'd81:  k = 11'sd43;   7'd82:  k = 11'sd38;   7'd83:  k = 11'sd34;   7'd84:  k = 11'sd29;
      7'd85:  k = 11'sd25;   7'd86:  k = 11'sd20;   7'd87:  k = 11'sd15;   7'd88:  k = 11'sd10;   7'd89:  k = 11'sd5;
      7'd90:  k = 11'sd0;    7'd91:  k = -11'sd5;   7'd92:  k = -11'sd11;  7'd93:  k = -11'sd16;  7'd94:  k = -11'sd22;
      7'd95:  k = -11'sd27;  7'd96:  k = -11'sd33;  7'd97:  k = -11'sd39;  7'd98:  k = -11'sd45;  7'd99:  k = -11'sd52;
      7'd100: k = -11'sd58;  7'd101: k = -11'sd65;  7'd102: k = -11'sd72;  7'd103: k = -11'sd79;  7'd104: k = -11'sd86;
      7'd105: k = -11'sd94;  7'd106: k = -11'sd102; 7'd107: k = -11'sd110; 7'd108: k = -11'sd118; 7'd109: k = -11'sd127;
      7'd110: k = -11'sd136; 7'd111: k = -11'sd146; 7'd112: k = -11'sd156; 7'd113: k = -11'sd166; 7'd114: k = -11'sd177;
      7'd115: k = -11'sd189; 7'd116: k = -11'sd201; 7'd117: k = -11'sd213; 7'd118: k = -11'sd227; 7'd119: k = -11'sd241;
      default: k = 11'sd0;
    endcase
    return k;
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [10:0] v);
    logic [7:0] c;
    if (v < 11'sd0)        c = 8'd0;
    else if (v > 11'sd255) c = 8'd255;
    else                   c = v[7:0];
    return c;
  endfunction

  // Hue reduction: values 360..511 wrap once, so 480..511 land in sector 1.
  logic [8:0] hn;
  logic [1:0] sector;
  logic [6:0] hp;

  assign hn = (iH >= 9'd360) ? (iH - 9'd360) : iH;

  always_comb begin
    sector = 2'd0;
    hp     = 7'(hn);
    if (hn < 9'd120) begin
      sector = 2'd0;
      hp     = 7'(hn);
    end else if (hn < 9'd240) begin
      sector = 2'd1;
      hp     = 7'(hn - 9'd120);
    end else begin
      sector = 2'd2;
      hp     = 7'(hn - 9'd240);
    end
  end

  // Stage registers
  logic              s1_valid, s2_valid, s3_valid;
  logic [1:0]        s1_sector, s2_sector, s3_sector;
  logic signed [10:0] s1_k, s2_k;
  logic [7:0]        s1_s, s1_i, s2_i, s3_i;
  logic [7:0]        s2_is, s2_lo, s3_lo;
  logic signed [10:0] s3_hi;

  // Stage 2 combinational: IS = (I*S) >> 8
  logic [15:0] i_times_s;
  logic [7:0]  is_next;
  assign i_times_s = {8'd0, s1_i} * {8'd0, s1_s};
  assign is_next   = 8'(i_times_s >> 8);

  // Stage 3 combinational: hi = I + floor(IS*K / 256)
  logic signed [19:0] is_k, is_k_sh;
  logic signed [10:0] hi_next;
  assign is_k    = $signed({12'd0, s2_is}) * $signed({{9{s2_k[10]}}, s2_k});
  assign is_k_sh = is_k >>> 8;
  assign hi_next = $signed({3'b000, s2_i}) + 11'(is_k_sh);

  // Stage 4 combinational: third component, clamp and sector routing
  logic signed [10:0] i_w, lo_w, third;
  logic [7:0] hi_c, third_c;
  logic [7:0] r_next, g_next, b_next;

  assign i_w     = $signed({3'b000, s3_i});
  assign lo_w    = $signed({3'b000, s3_lo});
  assign third   = i_w + i_w + i_w - lo_w - s3_hi;
  assign hi_c    = clamp8(s3_hi);
  assign third_c = clamp8(third);

  always_comb begin
    r_next = hi_c;
    g_next = third_c;
    b_next = s3_lo;
    case (s3_sector)
      2'd1: begin
        r_next = s3_lo;
        g_next = hi_c;
        b_next = third_c;
      end
      2'd2: begin
        r_next = third_c;
        g_next = s3_lo;
        b_next = hi_c;
      end
      default: begin
        r_next = hi_c;
        g_next = third_c;
        b_next = s3_lo;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_sector <= 2'd0;
      s1_k      <= 11'sd0;
      s1_s      <= 8'd0;
      s1_i      <= 8'd0;
      s2_valid  <= 1'b0;
      s2_sector <= 2'd0;
      s2_k      <= 11'sd0;
      s2_i      <= 8'd0;
      s2_is     <= 8'd0;
      s2_lo     <= 8'd0;
      s3_valid  <= 1'b0;
      s3_sector <= 2'd0;
      s3_i      <= 8'd0;
      s3_lo     <= 8'd0;
      s3_hi     <= 11'sd0;
      oValid    <= 1'b0;
      oR        <= 8'd0;
      oG        <= 8'd0;
      oB        <= 8'd0;
    end else if (iEn) begin
      s1_valid  <= iValid;
      s1_sector <= sector;
      s1_k      <= k_lut(hp);
      s1_s      <= iS;
      s1_i      <= iI;
      s2_valid  <= s1_valid;
      s2_sector <= s1_sector;
      s2_k      <= s1_k;
      s2_i      <= s1_i;
      s2_is     <= is_next;
      s2_lo     <= s1_i - is_next;
      s3_valid  <= s2_valid;
      s3_sector <= s2_sector;
      s3_i      <= s2_i;
      s3_lo     <= s2_lo;
      s3_hi     <= hi_next;
      oValid    <= s3_valid;
      oR        <= r_next;
      oG        <= g_next;
      oB        <= b_next;
    end
  end

endmodule

// File: tb/tb_hsi2rgb_pipe.sv
// Directed, table-driven bench for hsi2rgb_pipe with an expected-output queue
// checked on every enabled edge, plus stall and mid-stream reset sequences.
module tb_hsi2rgb_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       iEn;
  logic       iValid;
  logic [8:0] iH;
  logic [7:0] iS;
  logic [7:0] iI;
  logic       oValid;
  logic [7:0] oR, oG, oB;

  always #5 clk = ~clk;

  hsi2rgb_pipe dut (
    .clk(clk), .rst(rst), .iEn(iEn), .iValid(iValid),
    .iH(iH), .iS(iS), .iI(iI),
    .oValid(oValid), .oR(oR), .oG(oG), .oB(oB)
  );

  typedef struct {
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] i;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  logic [24:0] exp_q [$];   // {valid, r, g, b}, one entry per enabled edge
  int n_checks = 0;
  int n_fail = 0;
  int n_out_valid = 0;
  logic mon_on = 1'b0;

  logic        en_s, rst_s, last_v;
  logic [23:0] last_rgb;
  logic [24:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_vec(input int idx, input int h, input int s, input int i,
                         input int r, input int g, input int b);
    vecs[idx].h = 9'(h);
    vecs[idx].s = 8'(s);
    vecs[idx].i = 8'(i);
    vecs[idx].r = 8'(r);
    vecs[idx].g = 8'(g);
    vecs[idx].b = 8'(b);
  endtask

  // Drive one cycle at the falling edge; idx < 0 means random don't-care data.
  task automatic drive(input logic en, input logic v, input int idx);
    logic [23:0] rgb;
    @(negedge clk);
    iEn    = en;
    iValid = v;
    rgb    = 24'd0;
    if (idx >= 0) begin
      iH  = vecs[idx].h;
      iS  = vecs[idx].s;
      iI  = vecs[idx].i;
      rgb = {vecs[idx].r, vecs[idx].g, vecs[idx].b};
    end else begin
      iH = 9'($urandom_range(0, 511));
      iS = 8'($urandom_range(0, 255));
      iI = 8'($urandom_range(0, 255));
    end
    if (en) exp_q.push_back({v, rgb});
  endtask

  task automatic flush();
    repeat (4) drive(1'b1, 1'b0, -1);
  endtask

  task automatic prefill();
    repeat (3) exp_q.push_back(25'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    iEn    = 1'b0;
    iValid = 1'b0;
    #1;
    check("reset_valid", oValid, 0);
    check("reset_r", oR, 0);
    check("reset_g", oG, 0);
    check("reset_b", oB, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    prefill();
    rst = 1'b1;
  endtask

  // Output monitor: each enabled edge pops one expectation, a disabled edge must hold.
  always @(posedge clk) begin
    en_s  = iEn;
    rst_s = rst;
    #1;
    if (mon_on && rst_s && rst) begin
      if (en_s) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_valid", oValid, e[24]);
          if (e[24] && oValid) begin
            check("out_r", oR, e[23:16]);
            check("out_g", oG, e[15:8]);
            check("out_b", oB, e[7:0]);
          end
          if (oValid) n_out_valid++;
        end
      end else begin
        check("hold_valid", oValid, last_v);
        if (last_v && oValid) check("hold_rgb", {oR, oG, oB}, last_rgb);
      end
    end
    last_v   = oValid;
    last_rgb = {oR, oG, oB};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            H    S    I    R    G    B
    set_vec(0,    0,   0, 100, 100, 100, 100);
    set_vec(1,    0, 255, 128, 255,   1,   1);
    set_vec(2,  120, 255, 128,   1, 255,   1);
    set_vec(3,  240, 255, 128,   1,   1, 255);
    set_vec(4,   60, 128, 100, 125, 125,  50);
    set_vec(5,  359, 255, 128, 255,   1,   8);
    set_vec(6,  400, 255, 128, 231, 152,   1);
    set_vec(7,   40, 255, 128, 231, 152,   1);
    set_vec(8,  500, 255, 128,   1, 255, 100);
    set_vec(9,  140, 255, 128,   1, 255, 100);
    set_vec(10,  30, 200, 200, 255, 200,  44);
    set_vec(11,  90, 255, 128, 128, 255,   1);
    set_vec(12, 100, 100,  50,  45,  74,  31);
    set_vec(13, 360, 255, 255, 255,   1,   1);
    set_vec(14, 479, 255, 128,   8, 255,   1);
    set_vec(15, 511, 255, 128,   1, 252, 131);
    set_vec(16, 480, 255, 128,   1, 255,   1);
    set_vec(17, 200, 255,   0,   0,   0,   0);
    set_vec(18, 300, 100, 150, 179,  92, 179);

    rst = 1'b0; iEn = 1'b0; iValid = 1'b0; iH = 9'd0; iS = 8'd0; iI = 8'd0;
    repeat (2) @(negedge clk);
    check("init_valid", oValid, 0);
    check("init_r", oR, 0);
    check("init_g", oG, 0);
    check("init_b", oB, 0);
    prefill();
    mon_on = 1'b1;
    rst    = 1'b1;

    // Grey pixel: exactly one output pulse
    n_out_valid = 0;
    drive(1'b1, 1'b1, 0);
    flush();
    check("grey_count", n_out_valid, 1);

    // Whole table back-to-back (primaries sit on consecutive cycles)
    n_out_valid = 0;
    for (int k = 0; k < NV; k++) drive(1'b1, 1'b1, k);
    flush();
    check("table_count", n_out_valid, NV);

    // Interleaved bubbles
    n_out_valid = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, k + 4);
      drive(1'b1, 1'b0, -1);
    end
    flush();
    check("bubble_count", n_out_valid, 4);

    // Stall mid-stream: disabled cycles carry junk that must be ignored
    n_out_valid = 0;
    for (int k = 1; k <= 4; k++) drive(1'b1, 1'b1, k);
    drive(1'b0, 1'b1, -1);
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, -1);
    drive(1'b0, 1'b1, -1);
    drive(1'b1, 1'b1, 6);
    flush();
    check("stall_count", n_out_valid, 6);

    // Reset with pixels in flight and one on the output
    for (int k = 7; k < 12; k++) drive(1'b1, 1'b1, k);
    #1;
    check("pre_reset_valid", oValid, 1);
    do_reset();
    n_out_valid = 0;
    drive(1'b1, 1'b1, 5);
    flush();
    check("post_reset_count", n_out_valid, 1);

    @(negedge clk);
    iEn    = 1'b0;
    iValid = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
